aes_inv_mixcolumns_seq: RTL and testbench

Sequential AES InvMixColumns unit for the decryption datapath. It takes a 128-bit state through a valid/ready handshake and processes one 32-bit column per clock. Multiplication is in GF(2^8) with polynomial 0x11B, using chained xtime (x2, x4, x8) to build the 09/0B/0D/0E coefficients. The result is returned through a second valid/ready handshake.

---
 rtl/aes_inv_mixcolumns_seq.sv | 167 ++++++++++++++++
 tb/tb_aes_inv_mixcolumns_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_mixcolumns_seq.sv
// ============================================================================
// Module   : aes_inv_mixcolumns_seq
// Brief    : Sequential AES InvMixColumns, one 32-bit column per clock, with
//            valid/ready on both sides. Define AES_MIXCOL_FWD_EN to add a
//            per-state fwd input selecting forward MixColumns.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module aes_inv_mixcolumns_seq #(
    parameter int NUM_COLS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
`ifdef AES_MIXCOL_FWD_EN
    input  logic         fwd,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    localparam int                  c_CNT_W    = 2;
    localparam logic [c_CNT_W-1:0]  c_LAST_COL = c_CNT_W'(NUM_COLS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [127:0]         r_work;
    logic [31:0]          w_cols [NUM_COLS];
    logic [31:0]          w_col_in;
    logic [31:0]          w_col_out;
    logic [127:0]         w_work_next;
`ifdef AES_MIXCOL_FWD_EN
    logic                 r_fwd;
`endif

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2    = xt(a[i]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

`ifdef AES_MIXCOL_FWD_EN
    function automatic logic [31:0] fwd_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m2 [4];
        logic [7:0] m3 [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            m2[i] = xt(a[i]);
            m3[i] = m2[i] ^ a[i];
        end
        return {m2[0] ^ m3[1] ^ a[2]  ^ a[3],
                a[0]  ^ m2[1] ^ m3[2] ^ a[3],
                a[0]  ^ a[1]  ^ m2[2] ^ m3[3],
                m3[0] ^ a[1]  ^ a[2]  ^ m2[3]};
    endfunction
`endif

    // Column c holds bytes 4c..4c+3; byte 0 sits in the MSBs.
    generate
        for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
            assign w_cols[c] = r_work[32*(NUM_COLS-c)-1 -: 32];
        end
    endgenerate

    assign w_col_in = w_cols[r_cnt];

`ifdef AES_MIXCOL_FWD_EN
    assign w_col_out = r_fwd ? fwd_col(w_col_in) : inv_col(w_col_in);
`else
    assign w_col_out = inv_col(w_col_in);
`endif

    always_comb begin
        w_work_next = r_work;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (r_cnt == c_CNT_W'(c)) begin
                w_work_next[32*(NUM_COLS-c)-1 -: 32] = w_col_out;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_work    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
`ifdef AES_MIXCOL_FWD_EN
            r_fwd     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        r_work   <= in_data;
                        r_cnt    <= '0;
                        in_ready <= 1'b0;
                        r_state  <= S_BUSY;
`ifdef AES_MIXCOL_FWD_EN
                        r_fwd    <= fwd;
`endif
                    end
                end
                S_BUSY: begin
                    r_work <= w_work_next;
                    r_cnt  <= r_cnt + 1'b1;
                    // Final column: publish the completed state directly.
                    if (r_cnt == c_LAST_COL) begin
                        out_data  <= w_work_next;
                        out_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_aes_inv_mixcolumns_seq.sv
// ============================================================================
// Module   : tb_aes_inv_mixcolumns_seq
// Brief    : Self-checking bench: GF(2^8) matrix model plus directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_aes_inv_mixcolumns_seq;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic         fwd = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_data;

    int n_cmp = 0;
    int n_err = 0;
    logic [127:0] exp_q [$];

    localparam logic [127:0] V1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] E1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V2 = 128'h4d7ebdf8_00000000_ffffffff_8e4da1bc;
    localparam logic [127:0] E2 = 128'h2d26314c_00000000_ffffffff_db135345;
    localparam logic [127:0] V3 = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
    localparam logic [127:0] E3 = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;

    aes_inv_mixcolumns_seq #(.NUM_COLS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
`ifdef AES_MIXCOL_FWD_EN
        .fwd       (fwd),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    // Shift-and-add GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p ^= aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic f);
        logic [7:0] base [4];
        logic [7:0] b;
        logic [127:0] r = '0;
        if (f) begin
            base[0] = 8'h02; base[1] = 8'h03; base[2] = 8'h01; base[3] = 8'h01;
        end else begin
            base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09;
        end
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                b = 8'h00;
                for (int k = 0; k < 4; k++)
                    b ^= gmul(s[127-8*(4*c+k) -: 8], base[(k - row + 4) % 4]);
                r[127-8*(4*c+row) -: 8] = b;
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: expected results queued at accept, checked while out_valid.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL spurious_out_valid: got out_valid=1 expected 0 (no pending state)");
                end else begin
                    check("scoreboard_out_data", out_data, exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready === 1'b1) exp_q.push_back(model(in_data, fwd));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] d, input logic f);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        fwd      = f;
        do begin
            @(negedge clk);
            n++;
        end while (in_ready !== 1'b1 && n < 50);
        if (in_ready !== 1'b1) check("accept_timeout", 128'(in_ready), 128'd1);
        tick();
        in_valid = 1'b0;
        in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
        fwd      = ~f;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (out_valid !== 1'b1 && lat < 40);
        if (out_valid !== 1'b1) check("out_valid_timeout", 128'(out_valid), 128'd1);
    endtask

    initial begin
        int lat;
        logic [127:0] held;

        // Pin the model to hand-computed vectors.
        check("model_inv_v1", model(V1, 1'b0), E1);
        check("model_inv_v2", model(V2, 1'b0), E2);
        check("model_fwd_v3", model(V3, 1'b1), E3);

        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", 128'(in_ready), 128'd1);
        check("reset_out_valid", 128'(out_valid), 128'd0);
        check("reset_out_data", out_data, 128'd0);
        tick();

        // Basic transform and latency.
        send(V1, 1'b0);
        wait_out(lat);
        check("latency_v1", 128'(lat), 128'd5);
        check("result_v1", out_data, E1);
        tick();

        // Zero and all-ones columns.
        send(V2, 1'b0);
        wait_out(lat);
        check("result_v2", out_data, E2);
        tick();

        // Backpressure in DONE.
        out_ready = 1'b0;
        send(V1, 1'b0);
        wait_out(lat);
        held = out_data;
        check("bp_result", held, E1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_valid", 128'(out_valid), 128'd1);
            check("bp_out_data", out_data, held);
            check("bp_in_ready", 128'(in_ready), 128'd0);
        end
        tick();
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        check("bp_release_out_valid", 128'(out_valid), 128'd0);
        check("bp_release_in_ready", 128'(in_ready), 128'd1);
        tick();

        // Input activity during BUSY must be ignored.
        send(V2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
            tick();
        end
        in_valid = 1'b0;
        wait_out(lat);
        check("busy_toggle_result", out_data, E2);
        tick();

        // Reset in the second BUSY cycle.
        send(V1, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midreset_in_ready", 128'(in_ready), 128'd1);
        for (int i = 0; i < 8; i++) begin
            check("midreset_out_valid", 128'(out_valid), 128'd0);
            @(negedge clk);
        end
        tick();
        send(V2, 1'b0);
        wait_out(lat);
        check("after_reset_result", out_data, E2);
        tick();

`ifdef AES_MIXCOL_FWD_EN
        send(V3, 1'b1);
        wait_out(lat);
        check("fwd_latency", 128'(lat), 128'd5);
        check("fwd_result", out_data, E3);
        tick();
        send(V1, 1'b0);
        wait_out(lat);
        check("inv_after_fwd", out_data, E1);
        tick();
`endif

        repeat (3) tick();
        check("queue_drained", 128'(exp_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
